req_gnt_arbiter: RTL and testbench

- Round-robin bus arbiter for N requesters. Produces the `gnt`, `adr` and pending-request signals that the downstream grant/address property checker samples on `posedge clk`.
- Each requester presents a request line and an 8-bit target address.
- The arbiter grants one requester at a time, latches that requester's address onto the shared bus, and enforces a maximum hold time so that every requester is served fairly.

---
 rtl/req_gnt_arbiter.sv | 131 +++++++++++++
 tb/tb_req_gnt_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/req_gnt_arbiter.sv
// Purpose : round-robin arbiter granting one of N requesters the shared bus and latching its address.
// Latency : grant registered 1 cycle after a request is sampled in IDLE; 2 dead cycles between tenures.
// Backpres: requesters hold req_in level until served; a tenure ends on request drop or after MAX_HOLD cycles.
//
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   req_in[N]        per-requester request level
//   adr_in[N*AW]     packed addresses, requester i at [i*AW +: AW]
//   gnt / gnt_vec    registered grant flag and one-hot grant vector
//   gnt_id           index of granted (or last granted) requester
//   adr              address captured from the winner on grant entry
//   req              registered: someone other than the grantee is requesting
//   busy             arbiter not idle
module req_gnt_arbiter #(
    parameter int N        = 4,
    parameter int AW       = 8,
    parameter int MAX_HOLD = 8,
    parameter int IDW      = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_in,
    input  logic [N*AW-1:0] adr_in,
    output logic            gnt,
    output logic [N-1:0]    gnt_vec,
    output logic [IDW-1:0]  gnt_id,
    output logic [AW-1:0]   adr,
    output logic            req,
    output logic            busy
);

    localparam int HW = $clog2(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [HW-1:0]   hold_cnt, hold_nxt;
    logic [IDW-1:0]  last_id, last_nxt;
    logic            gnt_nxt;
    logic [N-1:0]    gnt_vec_nxt;
    logic [IDW-1:0]  gnt_id_nxt;
    logic [AW-1:0]   adr_nxt;
    logic            req_nxt;

    // Round-robin pick: first set request strictly after last_id, wrapping.
    logic            found;
    logic [IDW-1:0]  win;

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (int'(last_id) + k) % N;
            if (!found && req_in[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        hold_nxt    = hold_cnt;
        last_nxt    = last_id;
        gnt_nxt     = gnt;
        gnt_vec_nxt = gnt_vec;
        gnt_id_nxt  = gnt_id;
        adr_nxt     = adr;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt   = GRANT;
                    gnt_nxt     = 1'b1;
                    gnt_vec_nxt = {{(N-1){1'b0}}, 1'b1} << win;
                    gnt_id_nxt  = win;
                    adr_nxt     = adr_in[win*AW +: AW];
                    hold_nxt    = '0;
                end
            end
            GRANT: begin
                hold_nxt = hold_cnt + HW'(1);
                // Voluntary drop and timeout may coincide; both take the same single exit.
                if (!req_in[gnt_id] || (hold_cnt == HW'(MAX_HOLD - 1))) begin
                    state_nxt   = RELEASE;
                    gnt_nxt     = 1'b0;
                    gnt_vec_nxt = '0;
                    last_nxt    = gnt_id;
                    hold_nxt    = '0;
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Looks at the grant vector being loaded, so the grantee never counts as contention.
        req_nxt = |(req_in & ~gnt_vec_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            last_id  <= IDW'(N - 1);
            gnt      <= 1'b0;
            gnt_vec  <= '0;
            gnt_id   <= '0;
            adr      <= '0;
            req      <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            last_id  <= last_nxt;
            gnt      <= gnt_nxt;
            gnt_vec  <= gnt_vec_nxt;
            gnt_id   <= gnt_id_nxt;
            adr      <= adr_nxt;
            req      <= req_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_req_gnt_arbiter.sv
module tb_req_gnt_arbiter;

    localparam int N   = 4;
    localparam int AW  = 8;
    localparam int MH  = 8;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_in;
    logic [N*AW-1:0] adr_in;
    logic            gnt;
    logic [N-1:0]    gnt_vec;
    logic [IDW-1:0]  gnt_id;
    logic [AW-1:0]   adr;
    logic            req;
    logic            busy;

    req_gnt_arbiter #(.N(N), .AW(AW), .MAX_HOLD(MH), .IDW(IDW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_in  (req_in),
        .adr_in  (adr_in),
        .gnt     (gnt),
        .gnt_vec (gnt_vec),
        .gnt_id  (gnt_id),
        .adr     (adr),
        .req     (req),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the bus, how long it has owned it, dead cycles left.
    int owner;
    int held;
    int dead;
    int last;
    int m_id;
    int m_adr;
    int m_req;

    int grant_ids[$];
    int grant_adrs[$];
    int run_lens[$];
    int run;
    logic prev_gnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner = -1; held = 0; dead = 0; last = N - 1;
        m_id = 0; m_adr = 0; m_req = 0;
    endtask

    task automatic model_step();
        if (owner >= 0) begin
            held++;
            if (!req_in[owner] || held == MH) begin
                last  = owner;
                owner = -1;
                dead  = 1;
            end
        end else if (dead > 0) begin
            dead--;
        end else if (req_in != '0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (last + k) % N;
                if (owner < 0 && req_in[c]) owner = c;
            end
            m_id  = owner;
            m_adr = int'(adr_in[owner*AW +: AW]);
            held  = 0;
        end
        m_req = 0;
        for (int i = 0; i < N; i++)
            if (req_in[i] && i != owner) m_req = 1;
    endtask

    task automatic check_all();
        chk("gnt",     32'(gnt),     32'(owner >= 0));
        chk("gnt_vec", 32'(gnt_vec), (owner >= 0) ? (32'd1 << owner) : 32'd0);
        chk("gnt_id",  32'(gnt_id),  32'(m_id));
        chk("adr",     32'(adr),     32'(m_adr));
        chk("req",     32'(req),     32'(m_req));
        chk("busy",    32'(busy),    32'((owner >= 0) || (dead > 0)));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        if (gnt && !prev_gnt) begin
            grant_ids.push_back(int'(gnt_id));
            grant_adrs.push_back(int'(adr));
        end
        if (gnt) run++;
        else if (prev_gnt) begin
            run_lens.push_back(run);
            run = 0;
        end
        prev_gnt = gnt;
    endtask

    task automatic set_adr(input int i, input int v);
        adr_in[i*AW +: AW] = AW'(v);
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic do_reset(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        chk({tag, "_gnt"},     32'(gnt),     32'd0);
        chk({tag, "_gnt_vec"}, 32'(gnt_vec), 32'd0);
        chk({tag, "_gnt_id"},  32'(gnt_id),  32'd0);
        chk({tag, "_adr"},     32'(adr),     32'd0);
        chk({tag, "_req"},     32'(req),     32'd0);
        chk({tag, "_busy"},    32'(busy),    32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        model_reset();
        prev_gnt = 1'b0;
        run = 0;
    endtask

    initial begin
        rst_n  = 1'b1;
        req_in = '0;
        adr_in = '0;
        model_reset();
        prev_gnt = 1'b0;
        run = 0;
        #1;
        do_reset("por");

        // Single requester, held for three sampling edges then dropped.
        set_adr(2, 100);
        req_in = 4'b0100;
        tick();
        chk("single_id",  32'(gnt_id),  32'd2);
        chk("single_vec", 32'(gnt_vec), 32'b0100);
        chk("single_adr", 32'(adr),     32'd100);
        chk("single_req", 32'(req),     32'd0);
        tick();
        tick();
        req_in = 4'b0000;
        tick();
        chk("single_drop_gnt", 32'(gnt), 32'd0);
        tick();
        chk("single_idle_busy", 32'(busy), 32'd0);

        // Round robin with everyone requesting: 5 tenures of 8 cycles each.
        do_reset("rst_rr");
        grant_ids.delete(); grant_adrs.delete(); run_lens.delete();
        set_adr(0, 10); set_adr(1, 20); set_adr(2, 30); set_adr(3, 40);
        req_in = 4'b1111;
        for (int c = 0; c < 49; c++) tick();
        req_in = 4'b0000;
        tick(); tick(); tick();
        chk("rr_count", 32'(grant_ids.size()), 32'd5);
        for (int g = 0; g < 5 && g < grant_ids.size(); g++) begin
            chk($sformatf("rr_id%0d", g),  32'(grant_ids[g]),  32'(g % 4));
            chk($sformatf("rr_adr%0d", g), 32'(grant_adrs[g]), 32'(10 * ((g % 4) + 1)));
        end
        for (int g = 0; g < 4 && g < run_lens.size(); g++)
            chk($sformatf("rr_len%0d", g), 32'(run_lens[g]), 32'(MH));

        // Priority wrap: after requester 3 is served, 3 and 0 both ask; 0 wins.
        do_reset("rst_wrap");
        req_in = 4'b1000;
        tick();
        chk("wrap_first", 32'(gnt_id), 32'd3);
        req_in = 4'b0000;
        tick(); tick();
        req_in = 4'b1001;
        tick();
        chk("wrap_id", 32'(gnt_id), 32'd0);
        req_in = 4'b0000;
        tick(); tick(); tick();

        // Address stays latched even when the requester's input address changes.
        set_adr(1, 100);
        req_in = 4'b0010;
        tick();
        chk("stab_id", 32'(gnt_id), 32'd1);
        set_adr(1, 55);
        tick(); tick();
        chk("stab_adr", 32'(adr), 32'd100);
        req_in = 4'b0000;
        tick();
        chk("stab_hold_adr", 32'(adr), 32'd100);
        tick();

        // Request dropped on the 8th granted cycle: timeout and release coincide.
        req_in = 4'b0100;
        tick();
        chk("sim_id", 32'(gnt_id), 32'd2);
        for (int c = 0; c < 7; c++) tick();
        req_in = 4'b0000;
        tick();
        chk("sim_gnt",  32'(gnt),  32'd0);
        chk("sim_busy", 32'(busy), 32'd1);
        tick();
        chk("sim_idle", 32'(busy), 32'd0);
        req_in = 4'b0110;
        tick();
        chk("sim_next_id", 32'(gnt_id), 32'd1);
        tick();

        // Asynchronous reset in the middle of a tenure.
        do_reset("rst_mid");
        req_in = 4'b1010;
        tick();
        chk("post_rst_id", 32'(gnt_id), 32'd1);
        req_in = 4'b0000;
        tick(); tick(); tick();

        // Random traffic: requests persist with high probability, addresses churn.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) req_in[i] = ~req_in[i];
            end
            if ($urandom_range(0, 3) == 0) adr_in = {$urandom, $urandom};
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
